// File: rtl/fpnew_pipe_out_fifo.sv
// Output pipeline for FPnew operation units: bubble-collapsing register stages
// followed by an optional ready-decoupling FIFO, with an occupancy counter.
module fpnew_pipe_out_fifo #(
  parameter int unsigned Width       = 32,
  parameter int unsigned NumPipeRegs = 0,
  parameter int unsigned FifoDepth   = 0,
  parameter type         TagType     = logic,
  parameter type         AuxType     = logic,
  localparam int unsigned CntW = (NumPipeRegs + FifoDepth > 0) ?
                                 $clog2(NumPipeRegs + FifoDepth + 1) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] result_i,
  input  logic [4:0]       status_i,
  input  logic             extension_bit_i,
  input  TagType           tag_i,
  input  AuxType           aux_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [Width-1:0] result_o,
  output logic [4:0]       status_o,
  output logic             extension_bit_o,
  output TagType           tag_o,
  output AuxType           aux_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic [CntW-1:0]  count_o
);

  typedef struct packed {
    logic [Width-1:0] result;
    logic [4:0]       status;
    logic             ext;
    TagType           tag;
    AuxType           aux;
  } payload_t;

  payload_t in_data, tail_data, out_data;
  logic     tail_valid, tail_ready;

  assign in_data = '{result: result_i, status: status_i, ext: extension_bit_i,
                     tag: tag_i, aux: aux_i};

  if (NumPipeRegs == 0) begin : g_no_pipe
    assign tail_valid = in_valid_i;
    assign tail_data  = in_data;
    assign in_ready_o = tail_ready;
  end else begin : g_pipe
    localparam int unsigned NP = NumPipeRegs;
    logic [NP-1:0] valid_q, valid_d;
    payload_t      data_q [NP];
    payload_t      data_d [NP];
    // Index k of src_* is the value presented to stage k; index NP is the tail.
    logic [NP:0]   rdy;
    logic [NP:0]   src_valid;
    payload_t      src_data [NP+1];

    always_comb begin
      src_valid   = {valid_q, in_valid_i};
      src_data[0] = in_data;
      for (int unsigned i = 0; i < NP; i++) src_data[i+1] = data_q[i];
      rdy[NP] = tail_ready;
      for (int unsigned i = NP; i > 0; i--) rdy[i-1] = rdy[i] | ~valid_q[i-1];
      valid_d = valid_q;
      data_d  = data_q;
      for (int unsigned i = 0; i < NP; i++) begin
        if (rdy[i]) valid_d[i] = src_valid[i];
        if (rdy[i] && src_valid[i]) data_d[i] = src_data[i];
      end
      if (flush_i) valid_d = '0;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < NP; i++) data_q[i] <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign in_ready_o = rdy[0];
    assign tail_valid = src_valid[NP];
    assign tail_data  = src_data[NP];
  end

  if (FifoDepth == 0) begin : g_no_fifo
    assign tail_ready  = out_ready_i;
    assign out_valid_o = tail_valid;
    assign out_data    = tail_data;
  end else begin : g_fifo
    localparam int unsigned FD = FifoDepth;
    localparam int unsigned PW = $clog2(FD);
    typedef logic [PW-1:0] ptr_t;

    payload_t mem_q [FD];
    payload_t mem_d [FD];
    ptr_t     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic     full_q, full_d, empty, push, pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (wr_ptr_q == rd_ptr_q) & ~full_q;
    assign push  = tail_valid & ~full_q;
    assign pop   = ~empty & out_ready_i;

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      full_d   = full_q;
      if (flush_i) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        full_d   = 1'b0;
      end else begin
        if (push) begin
          mem_d[wr_ptr_q] = tail_data;
          wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      full_d = (ptr_inc(wr_ptr_q) == rd_ptr_q);
        else if (pop && !push) full_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < FD; i++) mem_q[i] <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        full_q   <= 1'b0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        full_q   <= full_d;
      end
    end

    // Upstream ready sees only the registered full flag, never out_ready_i.
    assign tail_ready  = ~full_q;
    assign out_valid_o = ~empty;
    assign out_data    = mem_q[rd_ptr_q];
  end

  if (NumPipeRegs + FifoDepth == 0) begin : g_no_cnt
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, flush_i};
    assign count_o     = '0;
    assign busy_o      = in_valid_i;
  end else begin : g_cnt
    logic [CntW-1:0] count_q, count_d;
    logic            in_fire, out_fire;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_comb begin
      count_d = count_q;
      if (flush_i) count_d = '0;
      else if (in_fire && !out_fire) count_d = count_q + CntW'(1);
      else if (out_fire && !in_fire) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
    end

    assign count_o = count_q;
    assign busy_o  = (count_q != '0);
  end

  assign result_o        = out_data.result;
  assign status_o        = out_data.status;
  assign extension_bit_o = out_data.ext;
  assign tag_o           = out_data.tag;
  assign aux_o           = out_data.aux;

endmodule

// File: tb/tb_fpnew_pipe_out_fifo.sv
// Scoreboard bench for fpnew_pipe_out_fifo over three configurations:
// A = 2 regs + 2-deep FIFO, B = 3 regs no FIFO, C = 1 reg + 3-deep FIFO.
module tb_fpnew_pipe_out_fifo;

  typedef logic [3:0] tag_t;
  typedef logic [2:0] aux_t;
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  status;
    logic        ext;
    tag_t        tag;
    aux_t        aux;
  } pay_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush;
  pay_t       in_p;
  logic [2:0] valid, ready, in_ready, out_valid, busy;
  logic [31:0] res [3];
  logic [4:0]  st  [3];
  logic        ext [3];
  tag_t        tg  [3];
  aux_t        ax  [3];
  pay_t        out_pay [3];
  int          cnt_i [3];
  logic [2:0]  cnt_a, cnt_c;
  logic [1:0]  cnt_b;

  int errors = 0;
  int checks = 0;
  pay_t qa[$], qb[$], qc[$];

  fpnew_pipe_out_fifo #(.Width(32), .NumPipeRegs(2), .FifoDepth(2),
                        .TagType(tag_t), .AuxType(aux_t)) dut_a (
    .clk_i(clk), .rst_i(rst), .result_i(in_p.result), .status_i(in_p.status),
    .extension_bit_i(in_p.ext), .tag_i(in_p.tag), .aux_i(in_p.aux),
    .in_valid_i(valid[0]), .in_ready_o(in_ready[0]), .flush_i(flush),
    .result_o(res[0]), .status_o(st[0]), .extension_bit_o(ext[0]), .tag_o(tg[0]),
    .aux_o(ax[0]), .out_valid_o(out_valid[0]), .out_ready_i(ready[0]),
    .busy_o(busy[0]), .count_o(cnt_a));

  fpnew_pipe_out_fifo #(.Width(32), .NumPipeRegs(3), .FifoDepth(0),
                        .TagType(tag_t), .AuxType(aux_t)) dut_b (
    .clk_i(clk), .rst_i(rst), .result_i(in_p.result), .status_i(in_p.status),
    .extension_bit_i(in_p.ext), .tag_i(in_p.tag), .aux_i(in_p.aux),
    .in_valid_i(valid[1]), .in_ready_o(in_ready[1]), .flush_i(flush),
    .result_o(res[1]), .status_o(st[1]), .extension_bit_o(ext[1]), .tag_o(tg[1]),
    .aux_o(ax[1]), .out_valid_o(out_valid[1]), .out_ready_i(ready[1]),
    .busy_o(busy[1]), .count_o(cnt_b));

  fpnew_pipe_out_fifo #(.Width(32), .NumPipeRegs(1), .FifoDepth(3),
                        .TagType(tag_t), .AuxType(aux_t)) dut_c (
    .clk_i(clk), .rst_i(rst), .result_i(in_p.result), .status_i(in_p.status),
    .extension_bit_i(in_p.ext), .tag_i(in_p.tag), .aux_i(in_p.aux),
    .in_valid_i(valid[2]), .in_ready_o(in_ready[2]), .flush_i(flush),
    .result_o(res[2]), .status_o(st[2]), .extension_bit_o(ext[2]), .tag_o(tg[2]),
    .aux_o(ax[2]), .out_valid_o(out_valid[2]), .out_ready_i(ready[2]),
    .busy_o(busy[2]), .count_o(cnt_c));

  assign out_pay[0] = {res[0], st[0], ext[0], tg[0], ax[0]};
  assign out_pay[1] = {res[1], st[1], ext[1], tg[1], ax[1]};
  assign out_pay[2] = {res[2], st[2], ext[2], tg[2], ax[2]};
  assign cnt_i[0]   = int'(cnt_a);
  assign cnt_i[1]   = int'(cnt_b);
  assign cnt_i[2]   = int'(cnt_c);

  function automatic pay_t rand_pay();
    pay_t p;
    p.result = $urandom;
    p.status = 5'($urandom);
    p.ext    = 1'($urandom);
    p.tag    = 4'($urandom);
    p.aux    = 3'($urandom);
    return p;
  endfunction

  // One cycle on DUT 'sel': inputs change at the falling edge, handshakes are
  // sampled 1 ns later and commit at the following rising edge.
  task automatic step(input int unsigned sel, input logic vv, input logic rr,
                      input logic fl, input pay_t p, output logic ifire,
                      output logic ofire, output pay_t op, output int cnt);
    @(negedge clk);
    in_p       = p;
    flush      = fl;
    valid      = '0;
    ready      = '0;
    valid[sel] = vv;
    ready[sel] = rr;
    #1;
    ifire = valid[sel] & in_ready[sel];
    ofire = out_valid[sel] & ready[sel];
    op    = out_pay[sel];
    cnt   = cnt_i[sel];
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; valid = '0; ready = '0; in_p = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int unsigned k = 0; k < 3; k++) begin
      checks++; if (out_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", k, out_valid[k]); end
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got=%b exp=0", k, busy[k]); end
      checks++; if (cnt_i[k] !== 0) begin errors++; $display("FAIL reset_count dut%0d got=%0d exp=0", k, cnt_i[k]); end
      checks++; if (out_pay[k] !== '0) begin errors++; $display("FAIL reset_payload dut%0d got=%h exp=0", k, out_pay[k]); end
      checks++; if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", k, in_ready[k]); end
    end
  endtask

  task automatic test_stream();
    pay_t p, op, exp;
    logic fi, fo;
    int c, peak = 0;
    int unsigned out_idx = 0;
    for (int unsigned t = 0; t < 10; t++) begin
      p = rand_pay();
      p.result = t + 1;
      step(0, t < 3, 1'b1, 1'b0, p, fi, fo, op, c);
      checks++; if (c != qa.size()) begin errors++; $display("FAIL stream_count t=%0d got=%0d exp=%0d", t, c, qa.size()); end
      if (c > peak) peak = c;
      if (fo) begin
        checks++;
        if (qa.size() == 0) begin errors++; $display("FAIL stream_extra got=%h exp=none", op); end
        else begin
          exp = qa.pop_front();
          if (op !== exp) begin errors++; $display("FAIL stream_data got=%h exp=%h", op, exp); end
        end
        checks++; if (t != 3 + out_idx) begin errors++; $display("FAIL stream_latency got=%0d exp=%0d", t, 3 + out_idx); end
        out_idx++;
      end
      if (fi) qa.push_back(p);
    end
    checks++; if (peak != 3) begin errors++; $display("FAIL stream_peak got=%0d exp=3", peak); end
    checks++; if (out_idx != 3) begin errors++; $display("FAIL stream_outputs got=%0d exp=3", out_idx); end
  endtask

  task automatic test_backpressure();
    pay_t p, op, exp;
    logic fi, fo;
    int c, acc = 0;
    for (int unsigned t = 0; t < 8; t++) begin
      p = rand_pay();
      p.result = 32'h10 + t;
      step(0, 1'b1, 1'b0, 1'b0, p, fi, fo, op, c);
      checks++; if (c != qa.size()) begin errors++; $display("FAIL bp_count t=%0d got=%0d exp=%0d", t, c, qa.size()); end
      if (fi) begin qa.push_back(p); acc++; end
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready[0]); end
    checks++; if (cnt_i[0] != 4) begin errors++; $display("FAIL bp_full_count got=%0d exp=4", cnt_i[0]); end
    for (int unsigned t = 0; t < 4; t++) begin
      step(0, 1'b0, 1'b1, 1'b0, rand_pay(), fi, fo, op, c);
      checks++; if (fo !== 1'b1) begin errors++; $display("FAIL bp_drain_rate t=%0d got=%b exp=1", t, fo); end
      if (fo && qa.size() != 0) begin
        exp = qa.pop_front();
        checks++; if (op !== exp) begin errors++; $display("FAIL bp_drain_data got=%h exp=%h", op, exp); end
      end
    end
    checks++; if (qa.size() != 0) begin errors++; $display("FAIL bp_leftover got=%0d exp=0", qa.size()); end
  endtask

  task automatic test_flush();
    pay_t p, op;
    logic fi, fo;
    int c;
    for (int unsigned t = 0; t < 3; t++) begin
      p = rand_pay();
      step(0, 1'b1, 1'b0, 1'b0, p, fi, fo, op, c);
      if (fi) qa.push_back(p);
    end
    p = rand_pay();
    p.result = 32'hA;
    step(0, 1'b1, 1'b0, 1'b1, p, fi, fo, op, c);
    checks++; if (c != 3) begin errors++; $display("FAIL flush_cycle_count got=%0d exp=3", c); end
    qa.delete();
    step(0, 1'b0, 1'b0, 1'b0, rand_pay(), fi, fo, op, c);
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy[0]); end
    checks++; if (c != 0) begin errors++; $display("FAIL flush_count got=%0d exp=0", c); end
    for (int unsigned t = 0; t < 6; t++) begin
      step(0, 1'b0, 1'b1, 1'b0, rand_pay(), fi, fo, op, c);
      checks++; if (fo !== 1'b0) begin errors++; $display("FAIL flush_ghost got=%h exp=none", op); end
    end
  endtask

  task automatic test_bubble();
    pay_t p, op, exp;
    logic fi, fo;
    int c;
    for (int unsigned t = 0; t < 6; t++) begin
      p = rand_pay();
      step(1, 1'b1, 1'b0, 1'b0, p, fi, fo, op, c);
      checks++; if (in_ready[1] !== (qb.size() < 3)) begin errors++; $display("FAIL bubble_in_ready t=%0d got=%b exp=%b", t, in_ready[1], qb.size() < 3); end
      checks++; if (c != qb.size()) begin errors++; $display("FAIL bubble_count t=%0d got=%0d exp=%0d", t, c, qb.size()); end
      if (fi) qb.push_back(p);
    end
    checks++; if (qb.size() != 3) begin errors++; $display("FAIL bubble_held got=%0d exp=3", qb.size()); end
    for (int unsigned t = 0; t < 6; t++) begin
      step(1, 1'b0, 1'b1, 1'b0, rand_pay(), fi, fo, op, c);
      if (fo) begin
        checks++;
        if (qb.size() == 0) begin errors++; $display("FAIL bubble_extra got=%h exp=none", op); end
        else begin
          exp = qb.pop_front();
          if (op !== exp) begin errors++; $display("FAIL bubble_data got=%h exp=%h", op, exp); end
        end
      end
    end
    checks++; if (qb.size() != 0) begin errors++; $display("FAIL bubble_leftover got=%0d exp=0", qb.size()); end
  endtask

  task automatic test_decouple();
    pay_t p, op, exp;
    logic fi, fo, ir, rr;
    int c, sent = 0;
    rr = 1'b1;
    for (int unsigned cyc = 0; cyc < 600 && (sent < 100 || qa.size() != 0); cyc++) begin
      p = rand_pay();
      step(0, sent < 100, rr, 1'b0, p, fi, fo, op, c);
      ir = in_ready[0];
      ready[0] = ~ready[0];
      #1;
      checks++; if (in_ready[0] !== ir) begin errors++; $display("FAIL ready_path cyc=%0d got=%b exp=%b", cyc, in_ready[0], ir); end
      ready[0] = ~ready[0];
      #1;
      checks++; if (c != qa.size()) begin errors++; $display("FAIL dec_count cyc=%0d got=%0d exp=%0d", cyc, c, qa.size()); end
      if (fo) begin
        checks++;
        if (qa.size() == 0) begin errors++; $display("FAIL dec_extra got=%h exp=none", op); end
        else begin
          exp = qa.pop_front();
          if (op !== exp) begin errors++; $display("FAIL dec_data got=%h exp=%h", op, exp); end
        end
      end
      if (fi) begin qa.push_back(p); sent++; end
      rr = ~rr;
    end
    checks++; if (sent != 100) begin errors++; $display("FAIL dec_sent got=%0d exp=100", sent); end
    checks++; if (qa.size() != 0) begin errors++; $display("FAIL dec_timeout pending=%0d exp=0", qa.size()); end
  endtask

  task automatic test_wrap_reset();
    pay_t p, op, exp;
    logic fi, fo;
    int c, popped = 0;
    for (int unsigned t = 0; t < 12; t++) begin
      p = rand_pay();
      step(2, t < 7, 1'b1, 1'b0, p, fi, fo, op, c);
      checks++; if (c != qc.size()) begin errors++; $display("FAIL wrap_count t=%0d got=%0d exp=%0d", t, c, qc.size()); end
      if (fo) begin
        checks++;
        if (qc.size() == 0) begin errors++; $display("FAIL wrap_extra got=%h exp=none", op); end
        else begin
          exp = qc.pop_front();
          if (op !== exp) begin errors++; $display("FAIL wrap_data got=%h exp=%h", op, exp); end
        end
        popped++;
      end
      if (fi) qc.push_back(p);
    end
    checks++; if (popped != 7) begin errors++; $display("FAIL wrap_popped got=%0d exp=7", popped); end
    for (int unsigned t = 0; t < 2; t++) begin
      p = rand_pay();
      step(2, 1'b1, 1'b0, 1'b0, p, fi, fo, op, c);
      if (fi) qc.push_back(p);
    end
    @(negedge clk);
    valid = '0; ready = '0;
    #1;
    checks++; if (cnt_i[2] != 2) begin errors++; $display("FAIL held_before_reset got=%0d exp=2", cnt_i[2]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    qc.delete();
    #1;
    checks++; if (out_valid[2] !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid[2]); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy[2]); end
    checks++; if (cnt_i[2] != 0) begin errors++; $display("FAIL rst_count got=%0d exp=0", cnt_i[2]); end
    checks++; if (out_pay[2] !== '0) begin errors++; $display("FAIL rst_payload got=%h exp=0", out_pay[2]); end
    checks++; if (in_ready[2] !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready[2]); end
    popped = 0;
    for (int unsigned t = 0; t < 5; t++) begin
      p = rand_pay();
      p.result = 32'h5;
      step(2, t == 0, 1'b1, 1'b0, p, fi, fo, op, c);
      if (fo) begin
        checks++;
        if (qc.size() == 0) begin errors++; $display("FAIL post_rst_extra got=%h exp=none", op); end
        else begin
          exp = qc.pop_front();
          if (op !== exp) begin errors++; $display("FAIL post_rst_data got=%h exp=%h", op, exp); end
        end
        checks++; if (t != 2) begin errors++; $display("FAIL post_rst_latency got=%0d exp=2", t); end
        popped++;
      end
      if (fi) qc.push_back(p);
    end
    checks++; if (popped != 1) begin errors++; $display("FAIL post_rst_outputs got=%0d exp=1", popped); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_decouple();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
